adder_seg_display: RTL



---
 rtl/adder_seg_display.sv | 130 +++++++++++++
 1 files changed

// File: rtl/adder_seg_display.sv
// ---------------------------------------------------------------------------
// adder_seg_display
//
// Output stage for the 3-bit ripple-carry adder. The 4-bit result
// {carry-out, sum} is captured on a load strobe and held. The held value is
// shown as a two-digit decimal number (00..15) on a time-multiplexed,
// active-low seven-segment display. A leading zero in the tens place is blanked.
//
// Parameters:
//   REFRESH_DIV : clock cycles each digit stays lit before switching (>= 2)
//
// Ports:
//   clk       in   system clock, rising-edge active
//   rst       in   synchronous active-high reset
//   sum_in    in   [2:0] adder sum
//   c_out_in  in   adder carry-out
//   load      in   capture strobe for {c_out_in, sum_in}
//   seg       out  [6:0] segments {g,f,e,d,c,b,a}, active low
//   an        out  [1:0] digit anodes, active low (an[0]=ones, an[1]=tens)
//   cap_valid out  high once at least one capture has happened since reset
// ---------------------------------------------------------------------------
module adder_seg_display #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sum_in,
    input  logic       c_out_in,
    input  logic       load,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       cap_valid
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    // Digit-select states
    localparam logic [0:0] ST_ONES = 1'b0;
    localparam logic [0:0] ST_TENS = 1'b1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    logic [3:0]       res_q,      res_d;
    logic             capValid_q, capValid_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [0:0]       digitSel_q, digitSel_d;

    logic             cntWrap;
    logic             tensDigit;
    logic [3:0]       onesDigit;

    // Active-low seven-segment pattern for a single decimal digit.
    // Codes above 9 never reach here; they fall back to a blank pattern.
    function automatic logic [6:0] decodeDigit(input logic [3:0] d);
        logic [6:0] pat;
        pat = SEG_BLANK;
        case (d)
            4'd0: pat = 7'b1000000;
            4'd1: pat = 7'b1111001;
            4'd2: pat = 7'b0100100;
            4'd3: pat = 7'b0110000;
            4'd4: pat = 7'b0011001;
            4'd5: pat = 7'b0010010;
            4'd6: pat = 7'b0000010;
            4'd7: pat = 7'b1111000;
            4'd8: pat = 7'b0000000;
            4'd9: pat = 7'b0010000;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

    // Capture path: load overwrites the held result, otherwise the adder
    // inputs are ignored. The valid flag is sticky after the first load.
    always_comb begin
        res_d      = res_q;
        capValid_d = capValid_q;
        if (load) begin
            res_d      = {c_out_in, sum_in};
            capValid_d = 1'b1;
        end
    end

    // Refresh path: free-running counter that wraps at REFRESH_DIV-1, and
    // the digit select flips on every wrap. This is independent of capture,
    // so a load on the wrap cycle lands together with the digit switch.
    always_comb begin
        cntWrap    = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        cnt_d      = cntWrap ? '0 : cnt_q + CNT_W'(1);
        digitSel_d = digitSel_q;
        if (cntWrap) begin
            digitSel_d = (digitSel_q == ST_ONES) ? ST_TENS : ST_ONES;
        end
    end

    // All state registers; reset wins over load.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q      <= '0;
            capValid_q <= 1'b0;
            cnt_q      <= '0;
            digitSel_q <= ST_ONES;
        end else begin
            res_q      <= res_d;
            capValid_q <= capValid_d;
            cnt_q      <= cnt_d;
            digitSel_q <= digitSel_d;
        end
    end

    // Decimal split of 0..15: only the values 10..15 have a non-zero tens digit.
    always_comb begin
        tensDigit = (res_q >= 4'd10);
        onesDigit = tensDigit ? (res_q - 4'd10) : res_q;
    end

    // Display drive straight from registered state, so the new value is
    // visible right after the capturing edge. A zero tens digit is blanked.
    always_comb begin
        an  = 2'b10;
        seg = decodeDigit(onesDigit);
        if (digitSel_q == ST_TENS) begin
            an  = 2'b01;
            seg = tensDigit ? decodeDigit(4'd1) : SEG_BLANK;
        end
    end

    assign cap_valid = capValid_q;

endmodule
